// File: rtl/adc_spi_sampler.sv
// Periodic 4-channel scanner for a 14-bit SPI mode-0 ADC.
// Packs one conversion per channel into a 56-bit frame with a 1-cycle valid strobe.
module adc_spi_sampler #(
  parameter int unsigned CLK_DIV       = 4,
  parameter int unsigned SAMPLE_PERIOD = 1000
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        enable,
  output logic        adc_cs_n,
  output logic        adc_sclk,
  output logic        adc_mosi,
  input  logic        adc_miso,
  output logic [55:0] adc_data,
  output logic        adc_data_valid,
  output logic        busy,
  output logic        overrun
);

  localparam int unsigned PW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PeriodLast = PW'(SAMPLE_PERIOD - 1);
  localparam logic [DW-1:0] DivLast    = DW'(CLK_DIV - 1);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StSetup = 3'd1;
  localparam logic [2:0] StShift = 3'd2;
  localparam logic [2:0] StHold  = 3'd3;
  localparam logic [2:0] StGap   = 3'd4;
  localparam logic [2:0] StDone  = 3'd5;

  logic [PW-1:0]    r_period;
  logic [2:0]       r_state;
  logic [DW-1:0]    r_div;
  logic [4:0]       r_half;
  logic [1:0]       r_ch;
  logic [15:0]      r_cmd;
  logic [13:0]      r_rx;
  logic [3:0][13:0] r_slot;
  logic [55:0]      r_data;

  logic             w_trigger;
  logic             w_div_end;
  logic [2:0]       w_state_nxt;
  logic [DW-1:0]    w_div_nxt;
  logic [4:0]       w_half_nxt;
  logic [1:0]       w_ch_nxt;
  logic [15:0]      w_cmd_nxt;
  logic [13:0]      w_rx_nxt;
  logic [3:0][13:0] w_slot_nxt;
  logic [55:0]      w_data_nxt;

  assign w_trigger = enable & ~PRESET & (r_period == PeriodLast);
  assign w_div_end = (r_div == DivLast);

  always_ff @(posedge PCLK) begin
    if (PRESET || !enable || (r_period == PeriodLast)) begin
      r_period <= '0;
    end else begin
      r_period <= r_period + 1'b1;
    end
  end

  // Each SHIFT half-period is CLK_DIV cycles; even halves drive sclk high.
  always_comb begin
    w_state_nxt = r_state;
    w_div_nxt   = w_div_end ? '0 : r_div + 1'b1;
    w_half_nxt  = r_half;
    w_ch_nxt    = r_ch;
    w_cmd_nxt   = r_cmd;
    w_rx_nxt    = r_rx;
    w_slot_nxt  = r_slot;
    w_data_nxt  = r_data;
    case (r_state)
      StIdle: begin
        w_div_nxt = '0;
        if (w_trigger) begin
          w_state_nxt = StSetup;
          w_ch_nxt    = 2'd0;
          w_cmd_nxt   = 16'h0000;
        end
      end
      StSetup: begin
        if (w_div_end) begin
          w_state_nxt = StShift;
          w_half_nxt  = 5'd0;
          w_rx_nxt    = {r_rx[12:0], adc_miso};
        end
      end
      StShift: begin
        if (w_div_end) begin
          if (r_half == 5'd31) begin
            w_state_nxt       = StHold;
            w_slot_nxt[r_ch]  = r_rx;
          end else begin
            w_half_nxt = r_half + 5'd1;
            // Odd->even half is an sclk rise; even->odd is a fall.
            if (r_half[0]) begin
              w_rx_nxt = {r_rx[12:0], adc_miso};
            end else begin
              w_cmd_nxt = {r_cmd[14:0], 1'b0};
            end
          end
        end
      end
      StHold: begin
        if (w_div_end) begin
          w_state_nxt = StGap;
        end
      end
      StGap: begin
        if (w_div_end) begin
          if (r_ch == 2'd3) begin
            w_state_nxt = StDone;
            w_data_nxt  = {r_slot[0], r_slot[1], r_slot[2], r_slot[3]};
          end else begin
            w_state_nxt = StSetup;
            w_ch_nxt    = r_ch + 2'd1;
            w_cmd_nxt   = {2'b00, r_ch + 2'd1, 12'h000};
          end
        end
      end
      StDone: begin
        w_state_nxt = StIdle;
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  // r_rx is 14 bits wide: the two leading bits of each 16-bit word fall off the top.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state <= StIdle;
      r_div   <= '0;
      r_half  <= '0;
      r_ch    <= '0;
      r_cmd   <= '0;
      r_rx    <= '0;
      r_slot  <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_div   <= w_div_nxt;
      r_half  <= w_half_nxt;
      r_ch    <= w_ch_nxt;
      r_cmd   <= w_cmd_nxt;
      r_rx    <= w_rx_nxt;
      r_slot  <= w_slot_nxt;
      r_data  <= w_data_nxt;
    end
  end

  assign adc_cs_n       = ~((r_state == StSetup) | (r_state == StShift) | (r_state == StHold));
  assign adc_sclk       = (r_state == StShift) & ~r_half[0];
  assign adc_mosi       = ((r_state == StSetup) | (r_state == StShift)) & r_cmd[15];
  assign adc_data       = r_data;
  assign adc_data_valid = (r_state == StDone);
  assign busy           = (r_state != StIdle);
  assign overrun        = w_trigger & busy;

endmodule

// File: tb/tb_adc_spi_sampler.sv
// Bench for adc_spi_sampler: two instances (no-overrun and overrun periods) checked each cycle
// against an offset-based timing model, with an ADC model returning random or fixed words.
module tb_adc_spi_sampler;

  localparam int D    = 2;
  localparam int NI   = 2;
  localparam int P0   = 400;
  localparam int P1   = 100;
  localparam int SCAN = 140 * D;
  localparam int CHC  = 35 * D;

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b1;
  logic        enable = 1'b1;
  logic        cs_n   [NI];
  logic        sclk   [NI];
  logic        mosi   [NI];
  logic        miso   [NI];
  logic        valid  [NI];
  logic        busy_o [NI];
  logic        ovr    [NI];
  logic [55:0] data   [NI];

  always #5 PCLK = ~PCLK;

  adc_spi_sampler #(.CLK_DIV(D), .SAMPLE_PERIOD(P0)) u_dut0 (
    .PCLK(PCLK), .PRESET(PRESET), .enable(enable),
    .adc_cs_n(cs_n[0]), .adc_sclk(sclk[0]), .adc_mosi(mosi[0]), .adc_miso(miso[0]),
    .adc_data(data[0]), .adc_data_valid(valid[0]), .busy(busy_o[0]), .overrun(ovr[0])
  );

  adc_spi_sampler #(.CLK_DIV(D), .SAMPLE_PERIOD(P1)) u_dut1 (
    .PCLK(PCLK), .PRESET(PRESET), .enable(enable),
    .adc_cs_n(cs_n[1]), .adc_sclk(sclk[1]), .adc_mosi(mosi[1]), .adc_miso(miso[1]),
    .adc_data(data[1]), .adc_data_valid(valid[1]), .busy(busy_o[1]), .overrun(ovr[1])
  );

  // Hand-computed expectations per instance.
  int          lit_spacing [NI] = '{400, 300};
  int          lit_ovr     [NI] = '{0, 2};
  int          lit_first   [NI] = '{681, 381};
  logic [15:0] lit_cmd     [4]  = '{16'h0000, 16'h1000, 16'h2000, 16'h3000};
  logic [55:0] lit_frame        = 56'hFFFC000FFFC000;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  int s_run   = 0;
  int rst_cyc = 0;
  bit nxt_rst = 1'b1;
  bit nxt_en  = 1'b1;
  bit pattern_mode = 1'b1;
  bit spacing_on   = 1'b1;

  bit          scan_on   [NI];
  int          start     [NI];
  logic [55:0] exp_data  [NI];
  logic [15:0] words     [NI][4];
  bit          prev_cs   [NI];
  bit          prev_sclk [NI];
  bit          prev_busy [NI];
  int          bitp      [NI];
  logic [15:0] cur_word  [NI];
  logic [15:0] cmd_rx    [NI];
  int          rises     [NI];
  int          rises_all [NI];
  int          cs_cnt    [NI];
  int          conv_ch   [NI];
  bit          cs_ab     [NI];
  int          busy_cnt  [NI];
  bit          busy_ab   [NI];
  int          last_valid[NI];
  int          ovr_cnt   [NI];
  bit          first_pending [NI];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Model, compare and ADC response for the current cycle, then advance the model.
  task automatic eval_cycle();
    for (int i = 0; i < NI; i++) begin
      int p_per, val, o, ch, p, h, k;
      bit trig, active;
      logic [15:0] cmd;
      logic [5:0] e_out;
      logic e_cs, e_sclk, e_mosi, e_valid, e_busy, e_ovr;
      p_per  = (i == 0) ? P0 : P1;
      val    = (cyc - s_run) % p_per;
      trig   = !PRESET && enable && (val == p_per - 1);
      o      = cyc - start[i];
      active = scan_on[i] && (o <= SCAN);
      ch     = 0;
      e_cs = 1'b1; e_sclk = 1'b0; e_mosi = 1'b0; e_valid = 1'b0; e_busy = 1'b0;
      if (active) begin
        e_busy = 1'b1;
        if (o == SCAN) begin
          e_valid     = 1'b1;
          exp_data[i] = {words[i][0][13:0], words[i][1][13:0],
                         words[i][2][13:0], words[i][3][13:0]};
        end else begin
          ch   = o / CHC;
          p    = o % CHC;
          cmd  = 16'(ch) << 12;
          e_cs = (p >= 34 * D);
          if (p < D) begin
            e_mosi = cmd[15];
          end else if (p < 33 * D) begin
            h      = (p - D) / D;
            e_sclk = (h % 2 == 0);
            k      = (h + 1) / 2;
            if (k <= 15) e_mosi = cmd[15 - k];
          end
        end
      end
      e_ovr = trig && active;
      e_out = {e_cs, e_sclk, e_mosi, e_valid, e_busy, e_ovr};
      check($sformatf("outputs[%0d] {cs_n,sclk,mosi,valid,busy,ovr}", i),
            64'({cs_n[i], sclk[i], mosi[i], valid[i], busy_o[i], ovr[i]}), 64'(e_out));
      check($sformatf("adc_data[%0d]", i), 64'(data[i]), 64'(exp_data[i]));

      // ADC: first bit after cs_n falls, next bit after each sclk fall, mosi taken on rise.
      if (prev_cs[i] && !cs_n[i]) begin
        conv_ch[i]  = active ? (o / CHC) : 0;
        cur_word[i] = pattern_mode ? ((conv_ch[i] % 2 == 0) ? 16'hFFFF : 16'hC000)
                                   : 16'($urandom);
        words[i][conv_ch[i]] = cur_word[i];
        bitp[i]   = 15;
        miso[i]   = cur_word[i][15];
        rises[i]  = 0;
        cs_cnt[i] = 0;
        cmd_rx[i] = '0;
        cs_ab[i]  = 1'b0;
      end
      if (!cs_n[i]) cs_cnt[i]++;
      if (!prev_sclk[i] && sclk[i]) begin
        cmd_rx[i] = {cmd_rx[i][14:0], mosi[i]};
        rises[i]++;
        rises_all[i]++;
      end
      if (prev_sclk[i] && !sclk[i]) begin
        if (bitp[i] > 0) bitp[i]--;
        miso[i] = cur_word[i][bitp[i]];
      end
      if (!prev_cs[i] && cs_n[i] && !cs_ab[i]) begin
        check($sformatf("sclk rises per cs[%0d]", i), 64'(rises[i]), 64'd16);
        check($sformatf("cs_n low cycles[%0d]", i), 64'(cs_cnt[i]), 64'd68);
        check($sformatf("mosi command[%0d]", i), 64'(cmd_rx[i]), 64'(lit_cmd[conv_ch[i]]));
      end

      if (!prev_busy[i] && busy_o[i]) begin
        busy_cnt[i] = 0;
        busy_ab[i]  = 1'b0;
      end
      if (busy_o[i]) busy_cnt[i]++;
      if (prev_busy[i] && !busy_o[i] && !busy_ab[i])
        check($sformatf("busy length[%0d]", i), 64'(busy_cnt[i]), 64'd281);

      if (ovr[i]) ovr_cnt[i]++;
      if (valid[i]) begin
        if (pattern_mode) check($sformatf("pattern frame[%0d]", i), 64'(data[i]), 64'(lit_frame));
        if (spacing_on && last_valid[i] >= 0) begin
          check($sformatf("valid spacing[%0d]", i), 64'(cyc - last_valid[i]),
                64'(lit_spacing[i]));
          check($sformatf("overruns per scan[%0d]", i), 64'(ovr_cnt[i]), 64'(lit_ovr[i]));
        end
        if (first_pending[i]) begin
          check($sformatf("first valid after reset[%0d]", i), 64'(cyc - rst_cyc),
                64'(lit_first[i]));
          first_pending[i] = 1'b0;
        end
        last_valid[i] = cyc;
        ovr_cnt[i]    = 0;
      end
      prev_cs[i]   = cs_n[i];
      prev_sclk[i] = sclk[i];
      prev_busy[i] = busy_o[i];

      if (PRESET) begin
        scan_on[i]       = 1'b0;
        exp_data[i]      = '0;
        cs_ab[i]         = 1'b1;
        busy_ab[i]       = 1'b1;
        last_valid[i]    = -1;
        ovr_cnt[i]       = 0;
        first_pending[i] = 1'b1;
      end else begin
        if (active && o == SCAN) scan_on[i] = 1'b0;
        if (trig && !active) begin
          scan_on[i] = 1'b1;
          start[i]   = cyc + 1;
        end
      end
    end
    if (PRESET) rst_cyc = cyc;
    if (PRESET || !enable) s_run = cyc + 1;
    cyc++;
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
    PRESET = nxt_rst;
    enable = nxt_en;
    @(negedge PCLK);
    eval_cycle();
  endtask

  initial begin
    bit found;
    for (int i = 0; i < NI; i++) begin
      miso[i] = 1'b0; scan_on[i] = 1'b0; start[i] = 0; exp_data[i] = '0;
      prev_cs[i] = 1'b1; prev_sclk[i] = 1'b0; prev_busy[i] = 1'b0; bitp[i] = 15;
      cur_word[i] = '0; cmd_rx[i] = '0; rises[i] = 0; rises_all[i] = 0; cs_cnt[i] = 0;
      conv_ch[i] = 0; cs_ab[i] = 1'b1; busy_cnt[i] = 0; busy_ab[i] = 1'b1;
      last_valid[i] = -1; ovr_cnt[i] = 0; first_pending[i] = 1'b0;
      for (int c = 0; c < 4; c++) words[i][c] = '0;
    end

    // Reset with enable high, then fixed-pattern periodic scans.
    nxt_rst = 1'b1;
    nxt_en  = 1'b1;
    repeat (3) tick();
    for (int i = 0; i < NI; i++)
      check($sformatf("no sclk in reset[%0d]", i), 64'(rises_all[i]), 64'd0);
    nxt_rst = 1'b0;
    repeat (1300) tick();

    // Random ADC words with enable toggling.
    pattern_mode = 1'b0;
    spacing_on   = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 299) == 0) nxt_en = !nxt_en;
      tick();
    end

    // Reset at the 8th sclk rise of ch1 on instance 0.
    nxt_en = 1'b1;
    found  = 1'b0;
    for (int n = 0; n < 3000 && !found; n++) begin
      tick();
      found = (rises[0] == 8) && (conv_ch[0] == 1) && !cs_n[0];
    end
    check("wait ch1 8th rise", 64'(found), 64'd1);
    nxt_rst = 1'b1;
    tick();
    nxt_rst = 1'b0;
    repeat (1200) tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
